// File: rtl/vector_loader.sv
// vector_loader: stream-to-vector assembler for the dot-product engine.
// Accepts one (a, b) element pair per cycle on a valid/ready stream and
// packs up to DIM pairs into wide A/B vectors. A finished vector waits in
// the fill buffer ("pending") until the output register is free. It is then
// presented on a valid/ready output together with its element count.
// Short vectors, which end early on InLast, are zero-padded in the upper
// slots.
module vector_loader #(
  parameter  int DIM          = 8,
  parameter  int A_DATA_WIDTH = 32,
  parameter  int B_DATA_WIDTH = 32,
  localparam int CNT_WIDTH    = $clog2(DIM + 1)
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [A_DATA_WIDTH-1:0]       InA,
  input  logic [B_DATA_WIDTH-1:0]       InB,
  input  logic                          InLast,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [DIM*A_DATA_WIDTH-1:0]   A,
  output logic [DIM*B_DATA_WIDTH-1:0]   B,
  output logic [CNT_WIDTH-1:0]          OutCount
);

  // Fill buffer: the vector currently being assembled.
  logic [DIM*A_DATA_WIDTH-1:0] fill_a_q, fill_a_d;
  logic [DIM*B_DATA_WIDTH-1:0] fill_b_q, fill_b_d;
  // Number of slots written so far. Once pending, it holds the final count.
  logic [CNT_WIDTH-1:0]        count_q, count_d;
  logic                        pending_q, pending_d;

  // Output register: the vector pair offered downstream.
  logic [DIM*A_DATA_WIDTH-1:0] a_q, a_d;
  logic [DIM*B_DATA_WIDTH-1:0] b_q, b_d;
  logic [CNT_WIDTH-1:0]        out_count_q, out_count_d;
  logic                        out_valid_q, out_valid_d;

  logic xfer;    // fill buffer moves into the output register this edge
  logic accept;  // an input pair is taken this edge

  // The only full buffer that can block input is a pending fill buffer.
  // That buffer frees up on this edge exactly when the output register
  // frees up, so InReady is driven by OutReady and never by InValid.
  assign InReady = Resetn && (!pending_q || !out_valid_q || OutReady);

  assign OutValid = out_valid_q;
  assign A        = a_q;
  assign B        = b_q;
  assign OutCount = out_count_q;

  // Compute the handshake events for the coming edge.
  always_comb begin
    xfer   = pending_q && (!out_valid_q || OutReady);
    accept = InValid && InReady;
  end

  // Compute the next fill-buffer state. A transfer clears the buffer first,
  // so a pair accepted on the same edge lands in slot 0.
  always_comb begin
    // NOTE: every signal gets a default before any branch assigns it, so no
    // path can leave a value unassigned and no latch is inferred.
    fill_a_d  = xfer ? '0   : fill_a_q;
    fill_b_d  = xfer ? '0   : fill_b_q;
    count_d   = xfer ? '0   : count_q;
    pending_d = xfer ? 1'b0 : pending_q;

    if (accept) begin
      for (int i = 0; i < DIM; i++) begin
        if (count_d == CNT_WIDTH'(i)) begin
          fill_a_d[i*A_DATA_WIDTH +: A_DATA_WIDTH] = InA;
          fill_b_d[i*B_DATA_WIDTH +: B_DATA_WIDTH] = InB;
        end
      end
      // The DIM-th element always closes the vector, whatever InLast says.
      if (InLast || (count_d == CNT_WIDTH'(DIM - 1))) begin
        pending_d = 1'b1;
      end
      count_d = count_d + CNT_WIDTH'(1);
    end
  end

  // Compute the next output-register state. The register loads on a
  // transfer. It drops valid on a plain downstream handshake and otherwise
  // holds its data.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    if (xfer) begin
      a_d         = fill_a_q;
      b_d         = fill_b_q;
      out_count_d = count_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    // NOTE: state is updated with non-blocking assignments so that all
    // flops sample their _d values from the same moment in the edge.
    if (!Resetn) begin
      // NOTE: the wide fill buffer is reset too, not only the control bits.
      // Zero padding of short vectors depends on unwritten slots starting
      // at zero, so the buffer cannot come out of reset with stale data.
      fill_a_q    <= '0;
      fill_b_q    <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_a_q    <= fill_a_d;
      fill_b_q    <= fill_b_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// Self-checking bench for vector_loader with DIM=4 and 8-bit elements.
// A behavioural model keeps a queue of completed vectors, each tagged with
// the edge on which it completed. OutValid, the output data and InReady are
// derived from that queue on every cycle. Directed scenarios add literal
// expectations on top of the model.
module tb_vector_loader;

  localparam int DIM = 4;
  localparam int AW  = 8;
  localparam int BW  = 8;
  localparam int CW  = $clog2(DIM + 1);

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [AW-1:0]       in_a;
  logic [BW-1:0]       in_b;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [DIM*AW-1:0]   a_vec;
  logic [DIM*BW-1:0]   b_vec;
  logic [CW-1:0]       out_count;

  vector_loader #(
    .DIM          (DIM),
    .A_DATA_WIDTH (AW),
    .B_DATA_WIDTH (BW)
  ) dut (
    .Clock    (clk),
    .Resetn   (rst_n),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .InA      (in_a),
    .InB      (in_b),
    .InLast   (in_last),
    .OutValid (out_valid),
    .OutReady (out_ready),
    .A        (a_vec),
    .B        (b_vec),
    .OutCount (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DIM*AW-1:0] a;
    logic [DIM*BW-1:0] b;
    int                cnt;
    int                done_edge;  // edge at which the last pair was accepted
  } vec_t;

  vec_t exp_q[$];
  int   fa[DIM];
  int   fb[DIM];
  int   fill_len  = 0;
  int   edge_n    = 0;
  int   last_pop  = 0;
  int   delivered = 0;
  bit   started   = 0;
  bit   post_rst  = 0;
  bit   exp_valid = 0;
  bit   exp_ready = 0;

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    // Compare against the state reached after edge edge_n.
    if (started) begin
      exp_ready = (rst_n === 1'b1) && !(exp_q.size() == 2 && out_ready !== 1'b1);
      exp_valid = 0;
      if (exp_q.size() > 0) begin
        int vis;
        vis = (exp_q[0].done_edge + 1 > last_pop) ? exp_q[0].done_edge + 1 : last_pop;
        exp_valid = (edge_n >= vis);
      end
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      if (post_rst) begin
        check("rst_a", {32'd0, a_vec}, 64'd0);
        check("rst_b", {32'd0, b_vec}, 64'd0);
        check("rst_count", {61'd0, out_count}, 64'd0);
      end
      if (exp_valid) begin
        check("out_a", {32'd0, a_vec}, {32'd0, exp_q[0].a});
        check("out_b", {32'd0, b_vec}, {32'd0, exp_q[0].b});
        check("out_count", {61'd0, out_count}, 64'(exp_q[0].cnt));
      end
    end
    // Apply the events of the coming edge edge_n+1 to the model.
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      fill_len  = 0;
      post_rst  = 1;
      started   = 1;
      exp_valid = 0;
      last_pop  = edge_n + 1;
    end else begin
      post_rst = 0;
      if (started) begin
        if (exp_valid && out_ready === 1'b1) begin
          void'(exp_q.pop_front());
          delivered++;
          last_pop = edge_n + 1;
        end
        if (in_valid === 1'b1 && exp_ready) begin
          fa[fill_len] = int'(in_a);
          fb[fill_len] = int'(in_b);
          fill_len++;
          if (in_last === 1'b1 || fill_len == DIM) begin
            vec_t v;
            v.a = '0;
            v.b = '0;
            for (int i = 0; i < fill_len; i++) begin
              v.a = v.a | ((DIM*AW)'(fa[i]) << (AW*i));
              v.b = v.b | ((DIM*BW)'(fb[i]) << (BW*i));
            end
            v.cnt       = fill_len;
            v.done_edge = edge_n + 1;
            exp_q.push_back(v);
            fill_len = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_or = 0;

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int  tries = 0;
    bit  done  = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        done = 1;
      end else begin
        tries++;
        if (tries > 300) begin
          check("send_timeout", 64'd0, 64'd1);
          done = 1;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 40);
    if (out_valid !== 1'b1) check("wait_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int d0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    idle(2);
    check("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Full vector: the output appears one cycle after the 4th accept.
    for (int i = 1; i <= 4; i++) send(8'(i), 8'(i + 4), 1'b0);
    wait_valid(n);
    check("full_latency", 64'(n), 64'd2);
    check("full_a", {32'd0, a_vec}, 64'h04030201);
    check("full_b", {32'd0, b_vec}, 64'h08070605);
    check("full_count", {61'd0, out_count}, 64'd4);
    idle(3);

    // Short vector with zero padding.
    send(8'd9, 8'd1, 1'b0);
    send(8'd10, 8'd2, 1'b1);
    wait_valid(n);
    check("short_a", {32'd0, a_vec}, 64'h00000A09);
    check("short_b", {32'd0, b_vec}, 64'h00000201);
    check("short_count", {61'd0, out_count}, 64'd2);
    idle(3);

    // Backpressure: 12 pairs with OutReady held low.
    d0 = delivered;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(8'(i), 8'(i + 8'h20), 1'b0);
      end
      begin
        repeat (20) @(negedge clk);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_valid_held", {63'd0, out_valid}, 64'd1);
        check("bp_a_held", {32'd0, a_vec}, 64'h04030201);
        check("bp_b_held", {32'd0, b_vec}, 64'h24232221);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(8);
    check("bp_delivered", 64'(delivered - d0), 64'd3);

    // Back-to-back streaming of the values 0..15.
    d0 = delivered;
    for (int i = 0; i < 16; i++) send(8'(i), 8'(8'hF0 | i), 1'b0);
    idle(4);
    check("b2b_delivered", 64'(delivered - d0), 64'd4);

    // Single-element vectors.
    d0 = delivered;
    for (int i = 0; i < 6; i++) send(8'(8'h50 + i), 8'(8'h60 + i), 1'b1);
    idle(4);
    check("single_delivered", 64'(delivered - d0), 64'd6);

    // Reset in the middle of a vector.
    send(8'h11, 8'h21, 1'b0);
    send(8'h12, 8'h22, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i), 8'(8'h41 + i), 1'b0);
    wait_valid(n);
    check("mid_rst_a", {32'd0, a_vec}, 64'h34333231);
    check("mid_rst_b", {32'd0, b_vec}, 64'h44434241);
    check("mid_rst_count", {61'd0, out_count}, 64'd4);
    idle(3);

    // Random traffic: gaps, early InLast and random backpressure.
    rand_or = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0));
    end
    rand_or = 0;
    #1;
    out_ready = 1'b1;
    idle(12);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
